pc_sequencer: RTL and testbench

Program-counter sequencer for the 8-bit core. It is the consumer of the jump-address adder's result: the adder computes PC + signed immediate, and this block registers that target and steers instruction fetch to it. It also handles sequential increment, call/return through a small hardware return stack, and halt/resume, and presents fetch addresses to instruction memory over a valid/ready handshake.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_sequencer_if.sv | 21 ++
 rtl/pc_ret_stack.sv | 49 ++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer:
// default widths, state encoding and next-PC select codes.
package pc_pkg;

  localparam int          ADDR_W_DEF   = 8;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_HALT  = 2'd1;
  localparam state_t ST_FAULT = 2'd2;

  typedef logic [1:0] sel_t;
  localparam sel_t SEL_INC  = 2'd0;
  localparam sel_t SEL_BR   = 2'd1;
  localparam sel_t SEL_CALL = 2'd2;
  localparam sel_t SEL_RET  = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch request channel between the PC sequencer
// (master) and instruction memory (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;

  modport master (
    output fetch_valid,
    output fetch_addr,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    output fetch_ready
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO; sp counts entries,
// so full/empty need no wrap-around tracking.
module pc_ret_stack #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] push_data_i,
  output logic [DW-1:0] top_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]   sp_q;
  logic [IW:0]   sp_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;

  assign wr_idx  = sp_q[IW-1:0];
  assign top_idx = sp_q[IW-1:0] - 1'b1;
  assign full_o  = (sp_q == (IW+1)'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_o   = mem_q[top_idx];

  // Stack pointer moves by one on push or pop.
  always_comb begin
    sp_d = sp_q;
    if (push_i)     sp_d = sp_q + 1'b1;
    else if (pop_i) sp_d = sp_q - 1'b1;
  end

  // Pointer register; reset empties the stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Entry storage; contents above sp are don't-care.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, branch, call/return
// via a return stack, halt/resume and sticky stack faults.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.master    fif,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic              halt,
  input  logic              resume,
  output logic              halted,
  output logic              fault,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  state_t            state_q, state_d;
  sel_t              sel;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              run;
  logic              push, pop;
  logic [ADDR_W-1:0] top;
  logic              full, empty;

  assign run    = (state_q == ST_RUN);
  assign push   = run && (sel == SEL_CALL) && !full;
  assign pop    = run && (sel == SEL_RET) && !empty;
  assign pc_out = pc_q;

  pc_ret_stack #(
    .DW    (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q + 1'b1),
    .top_o       (top),
    .full_o      (full),
    .empty_o     (empty)
  );

  // Redirect priority: ret over call over branch.
  always_comb begin
    sel = SEL_INC;
    if (ret_en)         sel = SEL_RET;
    else if (call_en)   sel = SEL_CALL;
    else if (branch_en) sel = SEL_BR;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state; a stack fault outranks halt.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if ((sel == SEL_RET && empty) ||
            (sel == SEL_CALL && full))
          state_d = ST_FAULT;
        else if (halt)
          state_d = ST_HALT;
      end
      ST_HALT: begin
        if (resume && !halt) state_d = ST_RUN;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  // Fetch is only offered in RUN and never during reset.
  always_comb begin
    fif.fetch_valid = run && !rst;
    fif.fetch_addr  = pc_q;
    halted          = (state_q == ST_HALT);
    fault           = (state_q == ST_FAULT);
    stack_overflow  = ovf_q;
    stack_underflow = unf_q;
  end

  // Next PC; a faulting call/ret leaves it untouched.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (run) begin
      unique case (sel)
        SEL_RET: begin
          if (!empty) pc_d  = top;
          else        unf_d = 1'b1;
        end
        SEL_CALL: begin
          if (!full) pc_d  = branch_target;
          else       ovf_d = 1'b1;
        end
        SEL_BR: pc_d = branch_target;
        default: begin
          if (!halt && fif.fetch_ready)
            pc_d = pc_q + 1'b1;
        end
      endcase
    end
  end

  // PC and sticky stack-error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference
// model predicts each cycle's outputs; a monitor compares them.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_out;
  logic       branch_en = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       call_en = 1'b0;
  logic       ret_en = 1'b0;
  logic       halt = 1'b0;
  logic       resume = 1'b0;
  logic       halted, fault;
  logic       stack_overflow, stack_underflow;

  pc_sequencer_if #(.ADDR_W(8)) fif ();

  pc_sequencer #(
    .ADDR_W      (8),
    .RESET_PC    (8'h00),
    .STACK_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fif             (fif),
    .pc_out          (pc_out),
    .branch_en       (branch_en),
    .branch_target   (branch_target),
    .call_en         (call_en),
    .ret_en          (ret_en),
    .halt            (halt),
    .resume          (resume),
    .halted          (halted),
    .fault           (fault),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: 0=running, 1=halted, 2=faulted
  int m_pc;
  int m_st;
  int m_stk[$];
  bit m_ovf, m_unf;

  logic [13:0] exq[$];

  function automatic logic [13:0] actv();
    return {fif.fetch_valid, halted, fault, stack_overflow,
            stack_underflow, fif.fetch_addr == pc_out, pc_out};
  endfunction

  function automatic logic [13:0] expv();
    logic [7:0] p;
    p = 8'(m_pc);
    return {m_st == 0, m_st == 1, m_st == 2, m_ovf, m_unf,
            1'b1, p};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (vld,hlt,flt,ovf,unf,addr_eq,pc)",
               name, act, exp);
    end
  endtask

  // monitor: one prediction consumed per cycle out of reset
  always @(negedge clk) begin
    if (!rst && exq.size() > 0) begin
      logic [13:0] e;
      e = exq.pop_front();
      chk("cycle", int'(actv()), int'(e));
    end
  end

  task automatic model_reset();
    m_pc = 0;
    m_st = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exq.delete();
    model_reset();
    branch_en = 0; call_en = 0; ret_en = 0;
    halt = 0; resume = 0; fif.fetch_ready = 0;
    @(posedge clk);
    #1;
    chk("in_reset", int'(actv()), int'({5'b0, 1'b1, 8'h00}));
    rst = 1'b0;
  endtask

  task automatic model_step(bit br, int tgt, bit call, bit ret,
                            bit hlt, bit res, bit rdy);
    if (m_st == 0) begin
      if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_unf = 1; m_st = 2; end
      end else if (call) begin
        if (m_stk.size() == 4) begin m_ovf = 1; m_st = 2; end
        else begin
          m_stk.push_back((m_pc + 1) % 256);
          m_pc = tgt;
        end
      end else if (br) m_pc = tgt;
      else if (!hlt && rdy) m_pc = (m_pc + 1) % 256;
      if (m_st == 0 && hlt) m_st = 1;
    end else if (m_st == 1) begin
      if (res && !hlt) m_st = 0;
    end
  endtask

  task automatic step(bit br, int tgt, bit call, bit ret,
                      bit hlt, bit res, bit rdy);
    exq.push_back(expv());
    branch_en = br;
    branch_target = 8'(tgt);
    call_en = call;
    ret_en = ret;
    halt = hlt;
    resume = res;
    fif.fetch_ready = rdy;
    model_step(br, tgt, call, ret, hlt, res, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fif.fetch_ready = 1'b0;
    model_reset();
    #2;
    do_reset();

    // sequential fetch, then stall
    repeat (4) step(0, 0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);

    // branch while memory stalls
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 8'h81, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // call, three increments, return
    step(1, 8'h10, 0, 0, 0, 0, 1);
    step(0, 8'h40, 1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // overflow on fifth nested call
    do_reset();
    for (int i = 0; i < 5; i++)
      step(0, 8'h20 + i, 1, 0, 0, 0, 1);
    step(1, 8'h77, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // underflow on empty return
    do_reset();
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // wrap, halt with redirect, ignored branch, resume
    do_reset();
    step(1, 8'hFF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 8'h20, 0, 0, 1, 0, 1);
    step(1, 8'h55, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // asynchronous reset in the middle of a call
    do_reset();
    step(0, 8'h30, 1, 0, 0, 0, 1);
    exq.push_back(expv());
    call_en = 1'b1;
    branch_target = 8'h60;
    fif.fetch_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", int'(actv()), int'({5'b0, 1'b1, 8'h00}));
    do_reset();
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_st == 2 && $urandom_range(3) == 0) do_reset();
      step($urandom_range(7) == 0, int'($urandom_range(255)),
           $urandom_range(6) == 0, $urandom_range(7) == 0,
           $urandom_range(15) == 0, $urandom_range(3) == 0,
           1'($urandom_range(1)));
    end

    @(negedge clk);
    #1;
    chk("drain", exq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
